// File: rtl/single_port_ram_pkg.sv
// Shared types and helpers for the single-port RAM arbiter and its RAM wrappers.
// No logic, so no latency and no backpressure.
package single_port_ram_pkg;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  function automatic int clogb2(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant; the pointer flips to the other port after each accepted grant.
// Latency: grant is combinational from valid; backpressure: none, the pointer only moves on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  // Granting port 0 hands priority to port 1 and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 1'b0;
    else if (accept) ptr <= grant[0];
  end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Shares one single-port no-change block RAM between two requesters, with optional zero scrub after reset.
// Latency: read data returns RD_LATENCY cycles after acceptance; backpressure: req_ready per port, none on responses.
module single_port_ram_arbiter
  import single_port_ram_pkg::*;
#(
  parameter int RAM_WIDTH      = 18,
  parameter int RAM_DEPTH      = 1024,
  parameter int RD_LATENCY     = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = clogb2(RAM_DEPTH)
) (
  input  logic                   clka,
  input  logic                   rsta_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*RAM_WIDTH-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [RAM_WIDTH-1:0]   rsp_rdata,
  output logic                   init_done,
  output logic [ADDR_W-1:0]      ram_addra,
  output logic [RAM_WIDTH-1:0]   ram_dina,
  output logic                   ram_wea,
  output logic                   ram_ena,
  output logic                   ram_rsta,
  output logic                   ram_regcea,
  input  logic [RAM_WIDTH-1:0]   ram_douta
);

  state_t              state;
  logic [ADDR_W-1:0]   scrub_addr;
  tag_t                tags [RD_LATENCY];
  tag_t                last;
  logic [1:0]          grant;
  logic                scrubbing, run, accept, gid, we_g;
  logic [ADDR_W-1:0]   addr_g;
  logic [RAM_WIDTH-1:0] wdata_g;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state      <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      scrub_addr <= '0;
    end else if (state == INIT) begin
      scrub_addr <= scrub_addr + ADDR_W'(1);
      if (scrub_addr == ADDR_W'(RAM_DEPTH - 1)) state <= RUN;
    end
  end

  // Gating with rsta_n keeps the RAM quiet while reset is held even though state already reads INIT/RUN.
  assign scrubbing = rsta_n && (state == INIT);
  assign run       = rsta_n && (state == RUN);
  assign init_done = run;
  assign ram_rsta  = !run;

  rr_arbiter2 u_arb (
    .clk    (clka),
    .rst_n  (rsta_n),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready = run ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gid       = grant[1];
  assign we_g      = req_we[gid];
  assign addr_g    = gid ? req_addr[2*ADDR_W-1 -: ADDR_W] : req_addr[ADDR_W-1:0];
  assign wdata_g   = gid ? req_wdata[2*RAM_WIDTH-1 -: RAM_WIDTH] : req_wdata[RAM_WIDTH-1:0];

  assign ram_ena   = scrubbing || accept;
  assign ram_wea   = scrubbing || (accept && we_g);
  assign ram_addra = scrubbing ? scrub_addr : addr_g;
  assign ram_dina  = scrubbing ? '0 : wdata_g;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: accept && !we_g, id: gid};
      for (int i = 1; i < RD_LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  assign last      = tags[RD_LATENCY-1];
  assign rsp_valid = {last.valid & last.id, last.valid & ~last.id};
  assign rsp_rdata = ram_douta;

  // The output register loads only on the cycle that carries read data out of the array.
  generate
    if (RD_LATENCY == 2) begin : g_high_perf
      assign ram_regcea = tags[0].valid;
    end else if (RD_LATENCY == 1) begin : g_low_lat
      assign ram_regcea = 1'b0;
    end else begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
      assign ram_regcea = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Directed bench: two arbiters (RD_LATENCY 2 and 1) share stimulus, each driving its own no-change RAM model.
module tb_single_port_ram_arbiter;

  localparam int W  = 18;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic            rsta_n;
  logic [1:0]      req_valid, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*W-1:0]  req_wdata;

  logic [1:0] rdy2, rv2, rdy1, rv1;
  logic [W-1:0] rd2, d2, dout2, lat2, rd1, d1, dout1;
  logic [AW-1:0] a2, a1;
  logic done2, we2, en2, rst2, ce2, done1, we1, en1, rst1, ce1;
  logic [W-1:0] mem2 [D];
  logic [W-1:0] mem1 [D];

  int total = 0;
  int bad   = 0;

  single_port_ram_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clka(clka), .rsta_n(rsta_n), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_rdata(rd2), .init_done(done2),
    .ram_addra(a2), .ram_dina(d2), .ram_wea(we2), .ram_ena(en2), .ram_rsta(rst2),
    .ram_regcea(ce2), .ram_douta(dout2));

  single_port_ram_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clka(clka), .rsta_n(rsta_n), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .init_done(done1),
    .ram_addra(a1), .ram_dina(d1), .ram_wea(we1), .ram_ena(en1), .ram_rsta(rst1),
    .ram_regcea(ce1), .ram_douta(dout1));

  // RAM models: garbage while reset is held so the scrub is observable.
  always @(posedge clka) begin
    if (!rsta_n) for (int i = 0; i < D; i++) mem2[i] <= W'(18'h2AAAA ^ i);
    else if (en2 && we2) mem2[a2] <= d2;
  end
  always @(posedge clka) if (en2 && !we2) lat2 <= mem2[a2];
  always @(posedge clka) begin
    if (rst2) dout2 <= '0;
    else if (ce2) dout2 <= lat2;
  end

  always @(posedge clka) begin
    if (!rsta_n) for (int i = 0; i < D; i++) mem1[i] <= W'(18'h15555 ^ i);
    else if (en1 && we1) mem1[a1] <= d1;
  end
  always @(posedge clka) begin
    if (rst1) dout1 <= '0;
    else if (en1 && !we1) dout1 <= mem1[a1];
  end

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic [1:0] v, input logic [1:0] we, input logic [AW-1:0] ad0,
                     input logic [AW-1:0] ad1, input logic [W-1:0] wd0, input logic [W-1:0] wd1);
    req_valid = v;
    req_we    = we;
    req_addr  = {ad1, ad0};
    req_wdata = {wd1, wd0};
    #1;
  endtask

  initial begin
    logic [1:0] e;
    logic [W-1:0] ed;

    rsta_n = 1'b0;
    set(2'b11, 2'b00, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("rst_ready2", rdy2, 2'b00);
    chk("rst_ready1", rdy1, 2'b00);
    chk("rst_rsp", rv2, 2'b00);
    chk("rst_done", done2, 0);
    chk("rst_ena", en2, 0);
    chk("rst_ena1", en1, 0);
    chk("rst_wea", we2, 0);
    chk("rst_regcea", ce2, 0);
    chk("rst_rsta", rst2, 1);

    // Scrub: 16 zero writes in address order, then RUN.
    set(2'b00, 2'b00, 0, 0, 0, 0);
    rsta_n = 1'b1;
    #1;
    for (int k = 0; k < D; k++) begin
      chk("scrub_ena", en2, 1);
      chk("scrub_wea", we2, 1);
      chk("scrub_addr", a2, k);
      chk("scrub_addr1", a1, k);
      chk("scrub_din", d2, 0);
      chk("scrub_done", done2, 0);
      chk("scrub_rsta", rst2, 1);
      cyc();
    end
    chk("init_done2", done2, 1);
    chk("init_done1", done1, 1);
    chk("run_ena", en2, 0);
    chk("run_rsta", rst2, 0);

    // Read of a scrubbed address.
    set(2'b01, 2'b00, 5, 0, 0, 0);
    chk("rd5_ready", rdy2, 2'b01);
    chk("rd5_ena", en2, 1);
    chk("rd5_wea", we2, 0);
    chk("rd5_addr", a2, 5);
    cyc();
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("rd5_rsp_l1", rv1, 2'b01);
    chk("rd5_data_l1", rd1, 0);
    chk("rd5_early_l2", rv2, 2'b00);
    chk("rd5_regcea", ce2, 1);
    cyc();
    chk("rd5_rsp_l2", rv2, 2'b01);
    chk("rd5_data_l2", rd2, 0);
    chk("rd5_once_l1", rv1, 2'b00);

    // Write then read back on the next cycle.
    set(2'b01, 2'b01, 3, 0, 18'h2A5A5, 0);
    chk("wr3_ena", en2, 1);
    chk("wr3_wea", we2, 1);
    chk("wr3_addr", a2, 3);
    chk("wr3_din", d2, 18'h2A5A5);
    cyc();
    set(2'b01, 2'b00, 3, 0, 0, 0);
    chk("rd3_ready", rdy2, 2'b01);
    chk("rd3_wea", we2, 0);
    cyc();
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("rd3_rsp_l1", rv1, 2'b01);
    chk("rd3_data_l1", rd1, 18'h2A5A5);
    chk("rd3_early_l2", rv2, 2'b00);
    cyc();
    chk("rd3_rsp_l2", rv2, 2'b01);
    chk("rd3_data_l2", rd2, 18'h2A5A5);
    chk("rd3_once_l1", rv1, 2'b00);
    cyc();
    chk("rd3_once_l2", rv2, 2'b00);

    // Preload for contention; pointer ends back at port 0.
    set(2'b01, 2'b01, 1, 0, 18'h00011, 0);
    cyc();
    set(2'b10, 2'b10, 0, 2, 0, 18'h00022);
    chk("pre_ready_p1", rdy2, 2'b10);
    cyc();

    // Contention: both read continuously, grants alternate starting with port 0.
    set(2'b11, 2'b00, 1, 2, 0, 0);
    for (int k = 0; k < 6; k++) begin
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_ready2", rdy2, e);
      chk("cont_ready1", rdy1, e);
      if (k >= 1) begin
        e  = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((k - 1) % 2 == 0) ? 18'h00011 : 18'h00022;
        chk("cont_rsp_l1", rv1, e);
        chk("cont_data_l1", rd1, ed);
      end
      if (k >= 2) begin
        e  = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
        ed = ((k - 2) % 2 == 0) ? 18'h00011 : 18'h00022;
        chk("cont_rsp_l2", rv2, e);
        chk("cont_data_l2", rd2, ed);
      end
      cyc();
    end
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("cont_tail_l1", rv1, 2'b10);
    chk("cont_tdata_l1", rd1, 18'h00022);
    chk("cont_tail_l2", rv2, 2'b01);
    chk("cont_tdata_l2", rd2, 18'h00011);
    cyc();
    chk("cont_last_l2", rv2, 2'b10);
    chk("cont_ldata_l2", rd2, 18'h00022);
    chk("cont_end_l1", rv1, 2'b00);
    cyc();
    chk("cont_end_l2", rv2, 2'b00);

    // No-change: a write issued between a read and its response leaves the response intact.
    set(2'b01, 2'b01, 7, 0, 18'h00077, 0);
    cyc();
    set(2'b01, 2'b00, 7, 0, 0, 0);
    chk("nc_rd_ready", rdy2, 2'b01);
    cyc();
    set(2'b10, 2'b10, 0, 8, 0, 18'h3FFFF);
    chk("nc_wr_ready", rdy2, 2'b10);
    chk("nc_rsp_l1", rv1, 2'b01);
    chk("nc_data_l1", rd1, 18'h00077);
    cyc();
    set(2'b01, 2'b01, 9, 0, 0, 0);
    chk("nc_rsp_l2", rv2, 2'b01);
    chk("nc_data_l2", rd2, 18'h00077);
    chk("nc_wr_norsp_l1", rv1, 2'b00);
    chk("nc_p0_ready", rdy2, 2'b01);
    cyc();
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("nc_wr_norsp_l2", rv2, 2'b00);

    // Idle: RAM untouched and pointer (now favouring port 1) preserved.
    for (int k = 0; k < 10; k++) begin
      chk("idle_ena", en2, 0);
      chk("idle_regcea", ce2, 0);
      chk("idle_ready", rdy2, 2'b00);
      cyc();
    end
    set(2'b11, 2'b00, 0, 8, 0, 0);
    chk("idle_ptr", rdy2, 2'b10);
    cyc();
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("rd8_rsp_l1", rv1, 2'b10);
    chk("rd8_data_l1", rd1, 18'h3FFFF);
    cyc();
    chk("rd8_rsp_l2", rv2, 2'b10);
    chk("rd8_data_l2", rd2, 18'h3FFFF);

    // Reset one cycle after a port 0 read is accepted; the pointer then favours port 1.
    set(2'b01, 2'b00, 7, 0, 0, 0);
    chk("mf_ready", rdy2, 2'b01);
    cyc();
    rsta_n = 1'b0;
    set(2'b00, 2'b00, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("mf_rsp_rst_l2", rv2, 2'b00);
      chk("mf_rsp_rst_l1", rv1, 2'b00);
      cyc();
    end
    rsta_n = 1'b1;
    set(2'b11, 2'b00, 7, 8, 0, 0);
    chk("mf_init_ready", rdy2, 2'b00);
    for (int k = 0; k < 40; k++) begin
      if (done2) break;
      chk("mf_rsp_init", rv2, 2'b00);
      cyc();
    end
    chk("mf_init_done", done2, 1);
    chk("mf_ptr_reset2", rdy2, 2'b01);
    chk("mf_ptr_reset1", rdy1, 2'b01);
    cyc();
    chk("mf_second_grant", rdy2, 2'b10);
    chk("mf_rd7_l1", rv1, 2'b01);
    chk("mf_rd7_data_l1", rd1, 0);
    cyc();
    set(2'b00, 2'b00, 0, 0, 0, 0);
    chk("mf_rd7_l2", rv2, 2'b01);
    chk("mf_rd7_data_l2", rd2, 0);
    cyc();
    chk("mf_rd8_l2", rv2, 2'b10);
    chk("mf_rd8_data_l2", rd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/single_port_ram_arbiter.md
Name: single_port_ram_arbiter

Overview:
- Shares one single-port no-change block RAM between two requesters, port 0 and port 1.
- Arbitration is round-robin, with at most one RAM access per cycle.
- Read data is routed back to the issuing requester after a fixed latency.
- After reset, an optional scrub sequencer zero-fills the RAM before any requester is admitted.
- Sits between client logic and the RAM macro; the RAM macro is instantiated externally.

Parameters:
- RAM_WIDTH, 18: data width; must match the RAM macro.
- RAM_DEPTH, 1024: number of entries; ADDR_W = clog2(RAM_DEPTH), so 10 at the default.
- RD_LATENCY, 2: RAM read latency. 2 selects the HIGH_PERFORMANCE output register; 1 selects LOW_LATENCY. Any other value is an elaboration error.
- CLEAR_ON_RESET, 1: 1 scrubs the whole RAM to zero after reset; 0 enters RUN directly.

Ports:
- clka  in  1  clock, shared with the RAM.
- rsta_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; the request transfers on valid&ready.
- req_we  in  2  per-requester write (1) or read (0).
- req_addr  in  2*ADDR_W  per-requester address, packed with port 0 in the LSBs.
- req_wdata  in  2*RAM_WIDTH  per-requester write data, packed.
- rsp_valid  out  2  read data valid for requester i, asserted for one cycle.
- rsp_rdata  out  RAM_WIDTH  read data; valid only when a bit of rsp_valid is set.
- init_done  out  1  high while in RUN.
- ram_addra  out  ADDR_W  to the RAM addra.
- ram_dina  out  RAM_WIDTH  to the RAM dina.
- ram_wea  out  1  to the RAM wea.
- ram_ena  out  1  to the RAM ena; high only on cycles with an access.
- ram_rsta  out  1  to the RAM rsta (its sync output-register reset).
- ram_regcea  out  1  to the RAM regcea.
- ram_douta  in  RAM_WIDTH  from the RAM douta.

Behaviour:
- Reset values (all outputs) while rsta_n is low:
  - req_ready=0, rsp_valid=0, init_done=0, ram_ena=0, ram_wea=0, ram_regcea=0.
  - ram_rsta=1.
  - Round-robin pointer = 0, meaning port 0 has priority.
  - Tag pipeline is cleared.
  - state = INIT if CLEAR_ON_RESET=1, else RUN.
- Reset asserted mid-operation: in-flight reads are discarded and no rsp_valid is produced for them. Requesters must reissue.
- State machine:
  - INIT: scrub counter runs 0..RAM_DEPTH-1, one write per cycle with ram_ena=1, ram_wea=1, ram_dina=0. req_ready=0 and ram_rsta=1. After the write to address RAM_DEPTH-1 the next state is RUN. INIT lasts exactly RAM_DEPTH cycles.
  - RUN: init_done=1 and ram_rsta=0. RUN is terminal until the next reset.
- Arbitration in RUN (combinational grant):
  - If only one req_valid is set, that port is granted.
  - If both are set, the port indicated by the pointer is granted.
  - req_ready[i] = RUN & grant[i]. req_ready depends combinationally on req_valid; it never depends on the response path.
  - On an accepted transfer, the pointer is set to the other port (pointer <= ~granted). It is unchanged on idle cycles.
  - A requester must hold valid and its payload stable until ready; the arbiter does not check this.
- RAM drive on an accepted transfer (combinational):
  - ram_ena=1, ram_wea=req_we[g].
  - ram_addra=req_addr[g], ram_dina=req_wdata[g].
  - With no transfer: ram_ena=0; addr and data hold last value or are don't-care.
- Tag pipeline:
  - Each accepted read pushes {valid=1, id=g} into a RD_LATENCY-deep shift register. Writes push valid=0.
  - At stage RD_LATENCY-1 (the last stage), rsp_valid[id] is asserted for one cycle and rsp_rdata=ram_douta. Read latency is therefore exactly RD_LATENCY cycles from acceptance to rsp_valid.
  - With RD_LATENCY=2: ram_regcea = stage0.valid, so the output register only loads on cycles carrying read data.
- Responses have no backpressure; clients must sink rsp_valid unconditionally.
- Throughput: one access per cycle, with reads and writes back-to-back in any mix.
- Write followed by read of the same address on the next cycle returns the new data.
- No-change mode: writes do not disturb ram_douta, so a write between a read and its response does not corrupt that response.
- Response order is global acceptance order, and therefore per-port in-order.
- Simultaneous write by port 0 and read by port 1 to the same address: only one is granted per cycle. The result follows grant order.

Decomposition:
- Package single_port_ram_pkg:
  - typedef state_t {INIT, RUN}.
  - typedef tag_t {logic valid; logic id}.
  - function clogb2, shared with the RAM modules.
- Sub-module rr_arbiter2: two-requester round-robin grant with pointer register; inputs valid[1:0] and accept, output grant[1:0].
- The tag pipeline and the INIT sequencer stay in the top module.

Test Plan:
- Scrub: CLEAR_ON_RESET=1, RAM_DEPTH=16, release reset -> exactly 16 writes to addresses 0..15 with data 0, then init_done=1. A read of address 5 then returns 0.
- Single port: port 0 writes addr 3 = 18'h2A5A5, then reads addr 3 on the next cycle -> rsp_valid=2'b01 exactly 2 cycles after read acceptance, rsp_rdata=18'h2A5A5. Repeat with RD_LATENCY=1 -> 1 cycle.
- Contention: both ports continuously reading (port 0 addr 1 = 18'h00011, port 1 addr 2 = 18'h00022) -> grants alternate 0,1,0,1. rsp_valid alternates 01,10 with matching data and no gaps.
- Mixed with no-change: port 0 reads addr 7 (= 18'h00077), and port 1 writes addr 8 = 18'h3FFFF in the next cycle -> port 0 still receives 18'h00077, and port 1 gets no response.
- Reset mid-flight: assert rsta_n low one cycle after a read is accepted -> no rsp_valid ever appears. After reset, the pointer is 0, so with both valid, port 0 is granted first.
- Idle: no req_valid for 10 cycles -> ram_ena=0 and ram_regcea=0 throughout, and the pointer is unchanged.
